ql_ram_arbiter: RTL and testbench

//  Shares the single QL RAM port between the file-download writer (one-cycle wr pulses, no

---
 rtl/ql_mem_pkg.sv | 27 ++
 rtl/ql_dl_fifo.sv | 73 +++++++
 rtl/ql_ram_arbiter.sv | 187 ++++++++++++++++++
 tb/tb_ql_ram_arbiter.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ql_mem_pkg.sv
// ----------------------------------------------------------------------------
// ql_mem_pkg
// Shared constants and types for the QL RAM arbitration slice.
//   QL_AW / QL_DW / QL_FIFO_LG2 : default RAM address width, data width and
//                                 log2 of the download FIFO depth
//   arb_state_t                 : arbiter FSM states
//   dl_entry_t                  : one queued download word {addr, data}
// ----------------------------------------------------------------------------
package ql_mem_pkg;

  localparam int QL_AW       = 25;
  localparam int QL_DW       = 16;
  localparam int QL_FIFO_LG2 = 3;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DL_WR    = 2'd1,
    CPU      = 2'd2,
    CPU_DONE = 2'd3
  } arb_state_t;

  typedef struct packed {
    logic [QL_AW-1:0] addr;
    logic [QL_DW-1:0] data;
  } dl_entry_t;

endpackage

// File: rtl/ql_dl_fifo.sv
// ----------------------------------------------------------------------------
// ql_dl_fifo
// Synchronous FIFO that buffers download words until the RAM port is free.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset (empties the FIFO)
//   push, din  : write request and data; accepted when not full, or when
//                full and a pop happens in the same cycle
//   pop        : remove the head entry (ignored when empty)
//   head       : current head entry
//   full/empty : occupancy flags
// ----------------------------------------------------------------------------
module ql_dl_fifo
  import ql_mem_pkg::*;
#(
  parameter int WIDTH = QL_AW + QL_DW,
  parameter int LG2   = QL_FIFO_LG2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int DEPTH = 1 << LG2;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [LG2-1:0]   wr_ptr_r;
  logic [LG2-1:0]   rd_ptr_r;
  logic [LG2:0]     count_r;
  logic             do_pop_s;
  logic             do_push_s;

  // count only reaches DEPTH (MSB set) when every slot is occupied
  assign full      = count_r[LG2];
  assign empty     = (count_r == {(LG2+1){1'b0}});
  assign do_pop_s  = pop & ~empty;
  // a full FIFO still takes a word when the head leaves in the same cycle
  assign do_push_s = push & (~full | do_pop_s);
  assign head      = mem[rd_ptr_r];

  // storage array; data contents need no reset
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem[wr_ptr_r] <= din;
    end
  end

  // pointers and occupancy counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {LG2{1'b0}};
      rd_ptr_r <= {LG2{1'b0}};
      count_r  <= {(LG2+1){1'b0}};
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + {{(LG2-1){1'b0}}, 1'b1};
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + {{(LG2-1){1'b0}}, 1'b1};
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + {{LG2{1'b0}}, 1'b1};
        2'b01:   count_r <= count_r - {{LG2{1'b0}}, 1'b1};
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/ql_ram_arbiter.sv
// ----------------------------------------------------------------------------
// ql_ram_arbiter
// Shares the single QL RAM port between the file-download writer and the
// 68008 CPU bus. Download words are queued in ql_dl_fifo and drained with
// priority; the CPU is held in reset while a download is active or draining.
// Ports:
//   clk, rst_n                          : clock, async active-low reset
//   dl_active, dl_wr, dl_addr, dl_data  : download controller side
//   cpu_req/we/be/addr/wdata            : CPU request (held until cpu_ack)
//   cpu_ack, cpu_rdata                  : one-cycle completion + read data
//   cpu_reset                           : hold-CPU-in-reset request
//   ram_req/we/be/addr/wdata            : RAM request, stable until ram_ack
//   ram_ack, ram_rdata                  : RAM completion + read data
//   dl_done                             : pulse once a finished download drained
//   dl_overflow                         : sticky, a download word was dropped
//   dl_sum                              : download checksum
// Configuration macro:
//   QL_DL_CHECKSUM_EN : when defined, dl_sum is the 16-bit wrap-around sum of
//                       accepted download words; otherwise dl_sum is 0.
// ----------------------------------------------------------------------------
module ql_ram_arbiter
  import ql_mem_pkg::*;
#(
  parameter int AW       = QL_AW,
  parameter int DW       = QL_DW,
  parameter int FIFO_LG2 = QL_FIFO_LG2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          dl_active,
  input  logic          dl_wr,
  input  logic [AW-1:0] dl_addr,
  input  logic [DW-1:0] dl_data,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [1:0]    cpu_be,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_ack,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_reset,
  output logic          ram_req,
  output logic          ram_we,
  output logic [1:0]    ram_be,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  input  logic          ram_ack,
  input  logic [DW-1:0] ram_rdata,
  output logic          dl_done,
  output logic          dl_overflow,
  output logic [DW-1:0] dl_sum
);

  arb_state_t          state_r;
  logic                dl_active_q_r;
  logic                done_pending_r;
  logic [AW+DW-1:0]    fifo_head_s;
  logic                fifo_full_s;
  logic                fifo_empty_s;
  logic                fifo_pop_s;
  logic                push_ok_s;
  logic                ovf_now_s;
  logic                dl_rise_s;
  logic                dl_fall_s;

  // head only leaves once its RAM write has completed
  assign fifo_pop_s = (state_r == DL_WR) & ram_req & ram_ack;
  assign push_ok_s  = dl_wr & (~fifo_full_s | fifo_pop_s);
  assign ovf_now_s  = dl_wr & fifo_full_s & ~fifo_pop_s;
  assign dl_rise_s  = dl_active & ~dl_active_q_r;
  assign dl_fall_s  = ~dl_active & dl_active_q_r;

  ql_dl_fifo #(
    .WIDTH (AW + DW),
    .LG2   (FIFO_LG2)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (dl_wr),
    .pop   (fifo_pop_s),
    .din   ({dl_addr, dl_data}),
    .head  (fifo_head_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s)
  );

  // arbiter FSM, RAM/CPU handshakes and download status flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r        <= IDLE;
      dl_active_q_r  <= 1'b0;
      done_pending_r <= 1'b0;
      cpu_ack        <= 1'b0;
      cpu_rdata      <= {DW{1'b0}};
      cpu_reset      <= 1'b1;
      ram_req        <= 1'b0;
      ram_we         <= 1'b0;
      ram_be         <= 2'b00;
      ram_addr       <= {AW{1'b0}};
      ram_wdata      <= {DW{1'b0}};
      dl_done        <= 1'b0;
      dl_overflow    <= 1'b0;
    end else begin
      dl_active_q_r <= dl_active;
      // dl_active_q_r bridges the cycle before done_pending_r is set
      cpu_reset <= dl_active | dl_active_q_r | ~fifo_empty_s | done_pending_r;

      if (dl_rise_s) begin
        dl_overflow <= ovf_now_s;
      end else if (ovf_now_s) begin
        dl_overflow <= 1'b1;
      end

      dl_done <= 1'b0;
      if (dl_fall_s) begin
        done_pending_r <= 1'b1;
      end else if (done_pending_r && fifo_empty_s && (state_r == IDLE) && !dl_active) begin
        done_pending_r <= 1'b0;
        dl_done        <= 1'b1;
      end

      cpu_ack <= 1'b0;
      case (state_r)
        IDLE: begin
          if (!fifo_empty_s) begin
            state_r <= DL_WR;
          end else if (cpu_req && !cpu_reset) begin
            state_r <= CPU;
          end else begin
            state_r <= IDLE;
          end
        end
        DL_WR: begin
          if (!ram_req) begin
            ram_req   <= 1'b1;
            ram_we    <= 1'b1;
            ram_be    <= 2'b11;
            ram_addr  <= fifo_head_s[AW+DW-1:DW];
            ram_wdata <= fifo_head_s[DW-1:0];
          end else if (ram_ack) begin
            ram_req <= 1'b0;
            state_r <= IDLE;
          end
        end
        CPU: begin
          if (!ram_req) begin
            ram_req   <= 1'b1;
            ram_we    <= cpu_we;
            // reads fetch the whole word; byte enables only matter on writes
            ram_be    <= cpu_we ? cpu_be : 2'b11;
            ram_addr  <= cpu_addr;
            ram_wdata <= cpu_wdata;
          end else if (ram_ack) begin
            ram_req   <= 1'b0;
            cpu_ack   <= 1'b1;
            cpu_rdata <= ram_rdata;
            state_r   <= CPU_DONE;
          end
        end
        CPU_DONE: begin
          // one request-free cycle so the CPU can drop cpu_req
          state_r <= IDLE;
        end
        default: begin
          ram_req <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

`ifdef QL_DL_CHECKSUM_EN
  // running sum of accepted download words, restarted per download
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dl_sum <= {DW{1'b0}};
    end else if (dl_rise_s) begin
      dl_sum <= push_ok_s ? dl_data : {DW{1'b0}};
    end else if (push_ok_s) begin
      dl_sum <= dl_sum + dl_data;
    end
  end
`else
  assign dl_sum = {DW{1'b0}};
`endif

endmodule

// File: tb/tb_ql_ram_arbiter.sv
// ----------------------------------------------------------------------------
// tb_ql_ram_arbiter
// Directed self-checking bench for ql_ram_arbiter: reset mid-access,
// download drain, overflow, CPU read/write, contention and checksum.
// ----------------------------------------------------------------------------
module tb_ql_ram_arbiter;

  logic        clk;
  logic        rst_n;
  logic        dl_active;
  logic        dl_wr;
  logic [24:0] dl_addr;
  logic [15:0] dl_data;
  logic        cpu_req;
  logic        cpu_we;
  logic [1:0]  cpu_be;
  logic [24:0] cpu_addr;
  logic [15:0] cpu_wdata;
  logic        cpu_ack;
  logic [15:0] cpu_rdata;
  logic        cpu_reset;
  logic        ram_req;
  logic        ram_we;
  logic [1:0]  ram_be;
  logic [24:0] ram_addr;
  logic [15:0] ram_wdata;
  logic        ram_ack;
  logic [15:0] ram_rdata;
  logic        dl_done;
  logic        dl_overflow;
  logic [15:0] dl_sum;

  int n_checks = 0;
  int n_fails  = 0;

  ql_ram_arbiter dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .dl_active   (dl_active),
    .dl_wr       (dl_wr),
    .dl_addr     (dl_addr),
    .dl_data     (dl_data),
    .cpu_req     (cpu_req),
    .cpu_we      (cpu_we),
    .cpu_be      (cpu_be),
    .cpu_addr    (cpu_addr),
    .cpu_wdata   (cpu_wdata),
    .cpu_ack     (cpu_ack),
    .cpu_rdata   (cpu_rdata),
    .cpu_reset   (cpu_reset),
    .ram_req     (ram_req),
    .ram_we      (ram_we),
    .ram_be      (ram_be),
    .ram_addr    (ram_addr),
    .ram_wdata   (ram_wdata),
    .ram_ack     (ram_ack),
    .ram_rdata   (ram_rdata),
    .dl_done     (dl_done),
    .dl_overflow (dl_overflow),
    .dl_sum      (dl_sum)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // waits for a RAM request, checks its fields, then acks after 'delay' cycles
  task automatic serve(input string tag, input logic exp_we, input logic chk_be,
                       input logic [1:0] exp_be, input logic [24:0] exp_addr,
                       input logic [15:0] exp_wdata, input logic [15:0] rdata,
                       input int delay);
    int n;
    n = 0;
    while (ram_req !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    chk({tag, " ram_req"}, 32'(ram_req), 32'd1);
    chk({tag, " ram_we"}, 32'(ram_we), 32'(exp_we));
    chk({tag, " ram_addr"}, 32'(ram_addr), 32'(exp_addr));
    if (chk_be) chk({tag, " ram_be"}, 32'(ram_be), 32'(exp_be));
    if (exp_we) chk({tag, " ram_wdata"}, 32'(ram_wdata), 32'(exp_wdata));
    repeat (delay) tick();
    ram_rdata = rdata;
    ram_ack   = 1'b1;
    tick();
    ram_ack   = 1'b0;
    chk({tag, " ram_req drop"}, 32'(ram_req), 32'd0);
  endtask

  task automatic push(input logic [24:0] a, input logic [15:0] d);
    dl_wr   = 1'b1;
    dl_addr = a;
    dl_data = d;
    tick();
    dl_wr   = 1'b0;
  endtask

  // ends on the cycle where dl_done is visible
  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (dl_done !== 1'b1 && n < 30) begin
      tick();
      n++;
    end
    chk({tag, " dl_done"}, 32'(dl_done), 32'd1);
  endtask

  initial begin
    int seen;
    logic [15:0] exp_sum;
    rst_n = 1'b0; dl_active = 1'b0; dl_wr = 1'b0; dl_addr = 25'd0; dl_data = 16'd0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_be = 2'b00; cpu_addr = 25'd0; cpu_wdata = 16'd0;
    ram_ack = 1'b0; ram_rdata = 16'd0;
    tick(); tick();

    // reset values
    chk("rst ram_req", 32'(ram_req), 32'd0);
    chk("rst cpu_reset", 32'(cpu_reset), 32'd1);
    chk("rst cpu_ack", 32'(cpu_ack), 32'd0);
    chk("rst dl_done", 32'(dl_done), 32'd0);
    chk("rst dl_overflow", 32'(dl_overflow), 32'd0);
    chk("rst dl_sum", 32'(dl_sum), 32'd0);
    rst_n = 1'b1;
    tick(); tick();
    chk("post-rst cpu_reset", 32'(cpu_reset), 32'd0);

    // 1. reset asserted mid CPU access
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 25'h00200;
    seen = 0;
    while (ram_req !== 1'b1 && seen < 20) begin tick(); seen++; end
    chk("t1 grant", 32'(ram_req), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("t1 async ram_req", 32'(ram_req), 32'd0);
    chk("t1 cpu_reset", 32'(cpu_reset), 32'd1);
    cpu_req = 1'b0;
    seen = 0;
    repeat (2) begin tick(); if (cpu_ack) seen++; end
    rst_n = 1'b1;
    repeat (4) begin tick(); if (cpu_ack || ram_req) seen++; end
    chk("t1 no ack/req", 32'(seen), 32'd0);
    chk("t1 fifo empty", 32'(cpu_reset), 32'd0);

    // 2. download of four words
    dl_active = 1'b1;
    tick();
    push(25'h380000, 16'h1111);
    push(25'h380001, 16'h2222);
    push(25'h380002, 16'h3333);
    push(25'h380003, 16'h4444);
    chk("t2 cpu_reset", 32'(cpu_reset), 32'd1);
`ifdef QL_DL_CHECKSUM_EN
    exp_sum = 16'hAAAA;
`else
    exp_sum = 16'h0000;
`endif
    chk("t2 dl_sum", 32'(dl_sum), 32'(exp_sum));
    serve("t2 w0", 1'b1, 1'b1, 2'b11, 25'h380000, 16'h1111, 16'h0000, 2);
    serve("t2 w1", 1'b1, 1'b1, 2'b11, 25'h380001, 16'h2222, 16'h0000, 2);
    serve("t2 w2", 1'b1, 1'b1, 2'b11, 25'h380002, 16'h3333, 16'h0000, 2);
    serve("t2 w3", 1'b1, 1'b1, 2'b11, 25'h380003, 16'h4444, 16'h0000, 2);
    dl_active = 1'b0;
    wait_done("t2");
    chk("t2 cpu_reset at done", 32'(cpu_reset), 32'd1);
    tick();
    chk("t2 done single", 32'(dl_done), 32'd0);
    chk("t2 cpu_reset fall", 32'(cpu_reset), 32'd0);
    seen = 0;
    repeat (5) begin tick(); if (dl_done) seen++; end
    chk("t2 no second done", 32'(seen), 32'd0);

    // 3. overflow: nine words, no ack
    dl_active = 1'b1;
    tick();
    for (int i = 0; i < 9; i++) push(25'h380100 + 25'(i), 16'h5000 + 16'(i));
    chk("t3 dl_overflow", 32'(dl_overflow), 32'd1);
`ifdef QL_DL_CHECKSUM_EN
    exp_sum = 16'h801C;
`else
    exp_sum = 16'h0000;
`endif
    chk("t3 dl_sum", 32'(dl_sum), 32'(exp_sum));
    for (int i = 0; i < 8; i++)
      serve("t3 w", 1'b1, 1'b1, 2'b11, 25'h380100 + 25'(i), 16'h5000 + 16'(i), 16'h0000, 1);
    seen = 0;
    repeat (4) begin tick(); if (ram_req) seen++; end
    chk("t3 ninth not written", 32'(seen), 32'd0);
    dl_active = 1'b0;
    wait_done("t3");
    tick(); tick();
    chk("t3 overflow sticky", 32'(dl_overflow), 32'd1);
    dl_active = 1'b1;
    tick();
    chk("t3 overflow cleared", 32'(dl_overflow), 32'd0);
    dl_active = 1'b0;
    wait_done("t3b");
    tick(); tick();
    chk("t3 cpu_reset low", 32'(cpu_reset), 32'd0);

    // 4. CPU read then a back-to-back write
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_be = 2'b11; cpu_addr = 25'h00100;
    serve("t4 rd", 1'b0, 1'b0, 2'b11, 25'h00100, 16'h0000, 16'hBEEF, 2);
    chk("t4 cpu_ack", 32'(cpu_ack), 32'd1);
    chk("t4 cpu_rdata", 32'(cpu_rdata), 32'h0000BEEF);
    cpu_we = 1'b1; cpu_be = 2'b01; cpu_addr = 25'h00101; cpu_wdata = 16'h1234;
    tick();
    chk("t4 ack one cycle", 32'(cpu_ack), 32'd0);
    chk("t4 idle gap", 32'(ram_req), 32'd0);
    serve("t4 wr", 1'b1, 1'b1, 2'b01, 25'h00101, 16'h1234, 16'h0000, 1);
    chk("t4 wr ack", 32'(cpu_ack), 32'd1);
    cpu_req = 1'b0;
    tick(); tick();

    // 5. contention: download starts while CPU access in flight
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 25'h00200;
    seen = 0;
    while (ram_req !== 1'b1 && seen < 20) begin tick(); seen++; end
    dl_active = 1'b1;
    push(25'h380200, 16'h0A01);
    push(25'h380201, 16'h0A02);
    push(25'h380202, 16'h0A03);
    serve("t5 cpu", 1'b0, 1'b0, 2'b11, 25'h00200, 16'h0000, 16'h1357, 1);
    chk("t5 cpu_ack", 32'(cpu_ack), 32'd1);
    chk("t5 cpu_rdata", 32'(cpu_rdata), 32'h00001357);
    cpu_addr = 25'h00300;
    serve("t5 w0", 1'b1, 1'b1, 2'b11, 25'h380200, 16'h0A01, 16'h0000, 1);
    serve("t5 w1", 1'b1, 1'b1, 2'b11, 25'h380201, 16'h0A02, 16'h0000, 1);
    serve("t5 w2", 1'b1, 1'b1, 2'b11, 25'h380202, 16'h0A03, 16'h0000, 1);
    tick(); tick();
    chk("t5 cpu held", 32'(ram_req), 32'd0);
    dl_active = 1'b0;
    wait_done("t5");
    chk("t5 no grant before done", 32'(ram_req), 32'd0);
    serve("t5 cpu2", 1'b0, 1'b0, 2'b11, 25'h00300, 16'h0000, 16'h2468, 1);
    chk("t5 cpu2 rdata", 32'(cpu_rdata), 32'h00002468);
    cpu_req = 1'b0;
    tick(); tick();

    // 6. checksum wrap-around
    dl_active = 1'b1;
    tick();
    push(25'h380300, 16'hFFFF);
    push(25'h380301, 16'h0002);
`ifdef QL_DL_CHECKSUM_EN
    exp_sum = 16'h0001;
`else
    exp_sum = 16'h0000;
`endif
    chk("t6 dl_sum", 32'(dl_sum), 32'(exp_sum));
    serve("t6 w0", 1'b1, 1'b1, 2'b11, 25'h380300, 16'hFFFF, 16'h0000, 0);
    serve("t6 w1", 1'b1, 1'b1, 2'b11, 25'h380301, 16'h0002, 16'h0000, 0);
    dl_active = 1'b0;
    wait_done("t6");
    chk("t6 overflow clear", 32'(dl_overflow), 32'd0);
    tick(); tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
